// File: rtl/captura_botones.sv
// Button front-end: per-button sync + debounce, press capture into a pending
// mask, and a one-strobe-per-command emitter feeding the command queue.

module captura_botones_db #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic db_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          s1_q, s2_q, db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The count restarts whenever s2 agrees with db, so a bounce resets it.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (s2_q != db_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = s2_q;
         else                                  cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= btn_i;
         s2_q  <= s1_q;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_o = db_q;
endmodule

module captura_botones #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int GAP_CYCLES      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_arriba,
   input  logic       btn_abajo,
   input  logic       btn_izquierda,
   input  logic       btn_derecha,
   input  logic       btn_centro,
   output logic       LE,
   output logic [2:0] boton_pres,
   output logic [4:0] pendientes
);
   localparam int GW = (GAP_CYCLES < 3) ? 2 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

   state_t        state_q, state_d;
   logic [4:0]    btn_raw, db, dbp_q, rise;
   logic [4:0]    pend_q, pend_d, sel;
   logic [2:0]    code_q, code_d, sel_code;
   logic          le_q, le_d;
   logic [GW-1:0] gap_q, gap_d;

   assign btn_raw = {btn_centro, btn_derecha, btn_izquierda, btn_abajo, btn_arriba};

   for (genvar g = 0; g < 5; g++) begin : g_btn
      captura_botones_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .btn_i (btn_raw[g]),
         .db_o  (db[g])
      );
   end

   assign rise = db & ~dbp_q;

   // Lowest set bit wins: code 1 has top priority.
   always_comb begin
      sel      = '0;
      sel_code = '0;
      for (int i = 4; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel      = '0;
            sel[i]   = 1'b1;
            sel_code = 3'(i + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dbp_q   <= '0;
         pend_q  <= '0;
         le_q    <= 1'b0;
         code_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         dbp_q   <= db;
         pend_q  <= pend_d;
         le_q    <= le_d;
         code_q  <= code_d;
         gap_q   <= gap_d;
      end
   end

   // The IDLE cycle that precedes the next strobe counts as the last gap cycle,
   // so GAP itself spans GAP_CYCLES-1 cycles and the period is 1+GAP_CYCLES.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pend_q != '0) state_d = EMIT;
         EMIT:    state_d = (GAP_CYCLES > 1) ? GAP : IDLE;
         GAP:     if (gap_q <= GW'(2)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      le_d   = 1'b0;
      code_d = '0;
      gap_d  = gap_q;
      pend_d = pend_q | rise;
      case (state_q)
         IDLE: if (pend_q != '0) begin
            le_d   = 1'b1;
            code_d = sel_code;
            pend_d = (pend_q & ~sel) | rise;
         end
         EMIT:    gap_d = GW'(GAP_CYCLES);
         GAP:     gap_d = gap_q - GW'(1);
         default: ;
      endcase
   end

   assign LE         = le_q;
   assign boton_pres = code_q;
   assign pendientes = pend_q;
endmodule

// File: tb/tb_captura_botones.sv
// Directed bench for captura_botones with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
// Each scenario is a per-edge table of button drives and expected strobes/mask.

module tb_captura_botones;
   logic       clk = 1'b0;
   logic       rst;
   logic       btn_arriba, btn_abajo, btn_izquierda, btn_derecha, btn_centro;
   logic       LE;
   logic [2:0] boton_pres;
   logic [4:0] pendientes;

   int checks = 0;
   int errors = 0;

   localparam int N = 48;
   int drv      [0:N-1];   // button mask {centro,derecha,izq,abajo,arriba} applied after edge e, -1 = hold
   int drv_rst  [0:N-1];   // rst applied after edge e, -1 = hold
   int exp_code [0:N-1];   // expected boton_pres after edge e (0 = no strobe)
   int exp_pend [0:N-1];   // expected pendientes after edge e, -1 = don't care

   always #5 clk = ~clk;

   captura_botones #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_arriba    (btn_arriba),
      .btn_abajo     (btn_abajo),
      .btn_izquierda (btn_izquierda),
      .btn_derecha   (btn_derecha),
      .btn_centro    (btn_centro),
      .LE            (LE),
      .boton_pres    (boton_pres),
      .pendientes    (pendientes)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_tables();
      for (int i = 0; i < N; i++) begin
         drv[i]      = -1;
         drv_rst[i]  = -1;
         exp_code[i] = 0;
         exp_pend[i] = -1;
      end
   endtask

   task automatic apply(input int e);
      logic [4:0] m;
      if (drv[e] >= 0) begin
         m = 5'(drv[e]);
         {btn_centro, btn_derecha, btn_izquierda, btn_abajo, btn_arriba} = m;
      end
      if (drv_rst[e] >= 0) rst = (drv_rst[e] != 0);
   endtask

   // Current time is just after "edge 0"; run edges 1..n checking each one.
   task automatic run(input string tag, input int n);
      apply(0);
      for (int e = 1; e <= n; e++) begin
         tick();
         chk($sformatf("%s e%0d LE", tag, e), 32'(LE), 32'(exp_code[e] != 0));
         chk($sformatf("%s e%0d code", tag, e), 32'(boton_pres), 32'(exp_code[e]));
         if (exp_pend[e] >= 0)
            chk($sformatf("%s e%0d pend", tag, e), 32'(pendientes), 32'(exp_pend[e]));
         apply(e);
      end
   endtask

   initial begin
      rst = 1'b1;
      {btn_centro, btn_derecha, btn_izquierda, btn_abajo, btn_arriba} = '0;
      tick(); tick(); tick();
      chk("rst LE", 32'(LE), 0);
      chk("rst code", 32'(boton_pres), 0);
      chk("rst pend", 32'(pendientes), 0);
      rst = 1'b0;

      // quiet after reset
      clear_tables();
      for (int e = 1; e <= 20; e++) exp_pend[e] = 0;
      run("idle", 20);

      // clean press of derecha: strobe code 4 after edge 8, nothing on hold or release
      clear_tables();
      drv[0] = 5'b01000;  drv[25] = 0;
      exp_pend[6] = 0;  exp_pend[7] = 5'b01000;  exp_pend[8] = 0;  exp_pend[30] = 0;
      exp_code[8] = 4;
      run("clean", 45);

      // bounce on arriba: 1,1,0,1,1,1,0 then steady high from after edge 7
      clear_tables();
      drv[0] = 1; drv[1] = 1; drv[2] = 0; drv[3] = 1; drv[4] = 1; drv[5] = 1; drv[6] = 0;
      drv[7] = 1; drv[31] = 0;
      exp_pend[13] = 0;  exp_pend[14] = 1;  exp_pend[15] = 0;
      exp_code[15] = 1;
      run("bounce", 45);

      // simultaneous centro+abajo+arriba: codes 1,2,5 three cycles apart
      clear_tables();
      drv[0] = 5'b10011;  drv[25] = 0;
      exp_pend[6] = 0;  exp_pend[7] = 5'b10011;  exp_pend[8] = 5'b10010;
      exp_pend[10] = 5'b10010;  exp_pend[11] = 5'b10000;
      exp_pend[13] = 5'b10000;  exp_pend[14] = 0;  exp_pend[20] = 0;
      exp_code[8] = 1;  exp_code[11] = 2;  exp_code[14] = 5;
      run("simul", 40);

      // re-press of arriba and a full izquierda press land while strobes are busy
      clear_tables();
      drv[0] = 5'b10011;  drv[5] = 5'b10010;  drv[8] = 5'b10110;  drv[9] = 5'b10111;
      drv[30] = 0;
      exp_pend[14] = 0;  exp_pend[15] = 5'b00100;  exp_pend[16] = 5'b00101;
      exp_pend[17] = 5'b00100;  exp_pend[20] = 0;  exp_pend[40] = 0;
      exp_code[8] = 1;  exp_code[11] = 2;  exp_code[14] = 5;
      exp_code[17] = 1; exp_code[20] = 3;
      run("merge", 45);

      // reset on the strobe cycle while two bits are pending
      clear_tables();
      drv[0] = 5'b10011;  drv[5] = 0;
      drv_rst[8] = 1;  drv_rst[9] = 0;
      exp_pend[7] = 5'b10011;  exp_pend[8] = 5'b10010;
      for (int e = 9; e <= 30; e++) exp_pend[e] = 0;
      exp_code[8] = 1;
      run("rstmid", 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
